ghost_line_renderer: RTL

//  Scanline renderer downstream of the 16x16 ghost sprite ROM (7-bit addr, 16-bit row; addr[3:0]=row, row 0 = top, bit 15 = leftmost px).

---
 rtl/pacman_pkg.sv | 16 +
 rtl/ghost_pixel_match.sv | 23 ++
 rtl/ghost_line_renderer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared screen/sprite constants and types for the ghost rendering path.
package pacman_pkg;

    localparam int SCREEN_W     = 640;
    localparam int H_ACTIVE_END = 640;
    localparam int V_TOTAL      = 525;
    localparam int SPR_SIZE     = 16;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        IDLE,
        FETCH
    } ghost_fetch_state_t;

endpackage

// File: rtl/ghost_pixel_match.sv
// Combinational hit test of one ghost's current line register against the beam X.
module ghost_pixel_match
    import pacman_pkg::*;
#(
    parameter int SPR_SIZE = pacman_pkg::SPR_SIZE
) (
    input  coord_t              draw_x,
    input  coord_t              ghost_x,
    input  logic [SPR_SIZE-1:0] line_row,
    output logic                hit
);

    localparam int CW = $clog2(SPR_SIZE);

    coord_t          col;
    logic [CW-1:0]   bit_sel;

    // Unsigned wrap puts beam positions left of the ghost far out of range.
    assign col     = draw_x - ghost_x;
    assign bit_sel = CW'(SPR_SIZE - 1) - col[CW-1:0];
    assign hit     = (col < coord_t'(SPR_SIZE)) && line_row[bit_sel];

endmodule

// File: rtl/ghost_line_renderer.sv
// Fetches one sprite row per ghost during hblank and produces registered per-pixel
// ghost hits with lowest-index priority; also owns the frightened blink counter.
module ghost_line_renderer
    import pacman_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int SPR_SIZE   = pacman_pkg::SPR_SIZE,
    parameter int V_TOTAL    = pacman_pkg::V_TOTAL,
    parameter int BLINK_BIT  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     line_start,
    input  logic                     frame_start,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [NUM_GHOSTS*10-1:0] ghost_x,
    input  logic [NUM_GHOSTS*10-1:0] ghost_y,
    output logic [6:0]               sprite_addr,
    input  logic [SPR_SIZE-1:0]      sprite_data,
    output logic                     ghost_hit,
    output logic [1:0]               ghost_idx,
    output logic                     blink,
    output logic                     fetch_busy
);

    ghost_fetch_state_t  state;
    logic [1:0]          gidx;
    coord_t              next_y;
    logic [6:0]          addr_q;
    logic [SPR_SIZE-1:0] line_reg [NUM_GHOSTS];
    logic [4:0]          frame_cnt;

    coord_t              cur_gy;
    coord_t              fetch_row;
    logic                row_ok;
    coord_t              y_inc;

    always_comb begin
        cur_gy = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (gidx == 2'(i)) cur_gy = ghost_y[i*10 +: 10];
        end
    end

    // A ghost below the next line wraps to a huge row and is skipped.
    assign fetch_row   = next_y - cur_gy;
    assign row_ok      = fetch_row < coord_t'(SPR_SIZE);
    assign sprite_addr = (state == FETCH && row_ok) ? {3'b000, fetch_row[3:0]} : addr_q;
    assign y_inc       = (DrawY == coord_t'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
    assign fetch_busy  = (state == FETCH);

    // Fetch FSM: one ghost per cycle, line_start always restarts at ghost 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            gidx   <= '0;
            next_y <= '0;
            addr_q <= '0;
            for (int i = 0; i < NUM_GHOSTS; i++) line_reg[i] <= '0;
        end else begin
            addr_q <= sprite_addr;
            if (state == FETCH) begin
                for (int i = 0; i < NUM_GHOSTS; i++) begin
                    if (gidx == 2'(i)) line_reg[i] <= row_ok ? sprite_data : '0;
                end
            end
            if (line_start) begin
                state  <= FETCH;
                gidx   <= '0;
                next_y <= y_inc;
            end else if (state == FETCH) begin
                if (gidx == 2'(NUM_GHOSTS - 1)) begin
                    state <= IDLE;
                    gidx  <= '0;
                end else begin
                    gidx <= gidx + 2'd1;
                end
            end
        end
    end

    // Stage p0: per-ghost combinational hit and priority encode.
    logic [NUM_GHOSTS-1:0] hit_p0;
    logic [1:0]            idx_p0;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_match
        ghost_pixel_match #(
            .SPR_SIZE (SPR_SIZE)
        ) u_match (
            .draw_x   (DrawX),
            .ghost_x  (ghost_x[g*10 +: 10]),
            .line_row (line_reg[g]),
            .hit      (hit_p0[g])
        );
    end

    always_comb begin
        idx_p0 = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (hit_p0[i]) idx_p0 = 2'(i);
        end
    end

    // Stage p1: registered pixel outputs to the colour mapper.
    logic       hit_p1;
    logic [1:0] idx_p1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_p1 <= 1'b0;
            idx_p1 <= '0;
        end else begin
            hit_p1 <= |hit_p0;
            idx_p1 <= idx_p0;
        end
    end

    assign ghost_hit = hit_p1;
    assign ghost_idx = idx_p1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 5'd1;
    end

    assign blink = frame_cnt[BLINK_BIT];

endmodule
